// File: rtl/axi4_mid_slave_mem.sv
// axi4_mid_slave_mem
// AXI4 MID slave endpoint backed by an on-chip array of 512-bit words.
// Read and write channels are independent FSMs sharing one memory array;
// each channel holds at most one transaction in flight.
module axi4_mid_slave_mem #(
    parameter int MEM_DEPTH   = 1024,
    parameter bit ENDIAN_SWAP = 1'b0,
    parameter int ADDR_LSB    = 6
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic [96:0]  s_axi_read_in,
    output logic [517:0] s_axi_read_out,
    input  logic [674:0] s_axi_write_in,
    output logic [5:0]   s_axi_write_out
);

    // Flat port layouts, MSB first.
    typedef struct packed {
        logic [63:0] araddr;
        logic [1:0]  arburst;
        logic [3:0]  arcache;
        logic        arid;
        logic [7:0]  arlen;
        logic [1:0]  arlock;
        logic [2:0]  arprot;
        logic [3:0]  arqos;
        logic [3:0]  arregion;
        logic [2:0]  arsize;
        logic        arvalid;
        logic        rready;
    } rd_in_t;

    typedef struct packed {
        logic         arready;
        logic [511:0] rdata;
        logic         rid;
        logic         rlast;
        logic [1:0]   rresp;
        logic         rvalid;
    } rd_out_t;

    typedef struct packed {
        logic [63:0]  awaddr;
        logic [1:0]   awburst;
        logic [3:0]   awcache;
        logic         awid;
        logic [7:0]   awlen;
        logic [1:0]   awlock;
        logic [2:0]   awprot;
        logic [3:0]   awqos;
        logic [3:0]   awregion;
        logic [2:0]   awsize;
        logic         awvalid;
        logic [511:0] wdata;
        logic         wlast;
        logic [63:0]  wstrb;
        logic         wvalid;
        logic         bready;
    } wr_in_t;

    typedef struct packed {
        logic       awready;
        logic       bid;
        logic [1:0] bresp;
        logic       bvalid;
        logic       wready;
    } wr_out_t;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    localparam int         IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [2:0] SIZE_64B    = 3'd6;

    // Byte reversal across the cacheline: byte i <-> byte 63-i.
    function automatic logic [511:0] swap_bytes(input logic [511:0] d);
        logic [511:0] s;
        for (int i = 0; i < 64; i++) s[i*8 +: 8] = d[(63-i)*8 +: 8];
        return s;
    endfunction

    function automatic logic [63:0] swap_strb(input logic [63:0] d);
        logic [63:0] s;
        for (int i = 0; i < 64; i++) s[i] = d[63-i];
        return s;
    endfunction

    // Per-beat response: range check outranks the size/burst-type check.
    function automatic logic [1:0] beat_resp(input logic [64:0] idx, input logic [1:0] burst,
                                             input logic [2:0] size);
        if (idx >= 65'(MEM_DEPTH))                return RESP_DECERR;
        else if (size != SIZE_64B || burst[1])    return RESP_SLVERR;
        else                                      return RESP_OKAY;
    endfunction

    // Codes are ordered so that the numerically larger one is the worse one.
    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    rd_in_t  rin;
    wr_in_t  win;
    rd_out_t rout;
    wr_out_t wout;

    assign rin = s_axi_read_in;
    assign win = s_axi_write_in;

    logic [511:0] mem [MEM_DEPTH];

    // Read channel state
    r_state_t     r_state;
    logic [63:0]  r_addr;
    logic [7:0]   r_len;
    logic [7:0]   r_beat;
    logic         r_id;
    logic [1:0]   r_burst;
    logic [2:0]   r_size;
    logic         arready_q;
    logic         rvalid_q;
    logic         rlast_q;
    logic [511:0] rdata_q;
    logic         rid_q;
    logic [1:0]   rresp_q;
    logic [64:0]  r_idx_full;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]   r_resp;

    // Write channel state
    w_state_t     w_state;
    logic [63:0]  w_addr;
    logic [7:0]   w_len;
    logic [7:0]   w_beat;
    logic         w_id;
    logic [1:0]   w_burst;
    logic [2:0]   w_size;
    logic [1:0]   w_err;
    logic         awready_q;
    logic         wready_q;
    logic         bvalid_q;
    logic         bid_q;
    logic [1:0]   bresp_q;
    logic [64:0]  w_idx_full;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]   w_resp;
    logic         w_last_beat;
    logic         w_end;
    logic [1:0]   w_worst;
    logic [511:0] wdata_in;
    logic [63:0]  wstrb_in;

    // Delayed memory write port
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [511:0]     mem_wdata;
    logic [63:0]      mem_wstrb;

    assign wdata_in = ENDIAN_SWAP ? swap_bytes(win.wdata) : win.wdata;
    assign wstrb_in = ENDIAN_SWAP ? swap_strb(win.wstrb) : win.wstrb;

    // Read beat address and response; FIXED bursts never advance the index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        r_idx_full = {1'b0, r_addr >> ADDR_LSB};
        if (r_burst != BURST_FIXED) r_idx_full = r_idx_full + 65'(r_beat);
        r_idx  = r_idx_full[IDX_W-1:0];
        r_resp = beat_resp(r_idx_full, r_burst, r_size);
    end

    // Write beat address, response and end-of-burst detection.
    always_comb begin
        w_idx_full = {1'b0, w_addr >> ADDR_LSB};
        if (w_burst != BURST_FIXED) w_idx_full = w_idx_full + 65'(w_beat);
        w_idx       = w_idx_full[IDX_W-1:0];
        w_resp      = beat_resp(w_idx_full, w_burst, w_size);
        w_last_beat = (w_beat == w_len);
        w_end       = win.wlast || w_last_beat;
        w_worst     = worst(w_err, w_resp);
        if (win.wlast != w_last_beat) w_worst = worst(w_worst, RESP_SLVERR);
    end

    // Read FSM: IDLE accepts AR, FETCH reads the array, DATA holds the beat until rready.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= R_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_id      <= 1'b0;
            r_burst   <= '0;
            r_size    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= 1'b0;
            rresp_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                R_IDLE: begin
                    if (arready_q && rin.arvalid) begin
                        r_addr    <= rin.araddr;
                        r_len     <= rin.arlen;
                        r_id      <= rin.arid;
                        r_burst   <= rin.arburst;
                        r_size    <= rin.arsize;
                        r_beat    <= '0;
                        arready_q <= 1'b0;
                        r_state   <= R_FETCH;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_FETCH: begin
                    if (r_resp == RESP_OKAY)
                        rdata_q <= ENDIAN_SWAP ? swap_bytes(mem[r_idx]) : mem[r_idx];
                    else
                        rdata_q <= '0;
                    rresp_q  <= r_resp;
                    rid_q    <= r_id;
                    rlast_q  <= (r_beat == r_len);
                    rvalid_q <= 1'b1;
                    r_state  <= R_DATA;
                end
                R_DATA: begin
                    if (rin.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: IDLE accepts AW, DATA consumes W beats, RESP holds B until bready.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state   <= W_IDLE;
            w_addr    <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_id      <= 1'b0;
            w_burst   <= '0;
            w_size    <= '0;
            w_err     <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 1'b0;
            bresp_q   <= '0;
            mem_we    <= 1'b0;
            mem_widx  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (awready_q && win.awvalid) begin
                        w_addr    <= win.awaddr;
                        w_len     <= win.awlen;
                        w_id      <= win.awid;
                        w_burst   <= win.awburst;
                        w_size    <= win.awsize;
                        w_beat    <= '0;
                        w_err     <= RESP_OKAY;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wready_q && win.wvalid) begin
                        mem_we    <= (w_resp == RESP_OKAY);
                        mem_widx  <= w_idx;
                        mem_wdata <= wdata_in;
                        mem_wstrb <= wstrb_in;
                        w_err     <= w_worst;
                        if (w_end) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= w_worst;
                            bid_q    <= w_id;
                            w_state  <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (win.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-strobed commit of an accepted write beat, one cycle after acceptance.
    always_ff @(posedge ap_clk) begin
        // NOTE: the array has no reset; contents survive ap_rst_n and map onto plain RAM.
        if (mem_we) begin
            for (int b = 0; b < 64; b++) begin
                if (mem_wstrb[b]) mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    // Pack registered outputs onto the flat ports.
    always_comb begin
        rout         = '0;
        rout.arready = arready_q;
        rout.rdata   = rdata_q;
        rout.rid     = rid_q;
        rout.rlast   = rlast_q;
        rout.rresp   = rresp_q;
        rout.rvalid  = rvalid_q;
        wout         = '0;
        wout.awready = awready_q;
        wout.bid     = bid_q;
        wout.bresp   = bresp_q;
        wout.bvalid  = bvalid_q;
        wout.wready  = wready_q;
    end

    assign s_axi_read_out  = rout;
    assign s_axi_write_out = wout;

    // Sideband fields carried by the interface but not used by this endpoint.
    logic unused_fields;
    assign unused_fields = ^{rin.arcache, rin.arlock, rin.arprot, rin.arqos, rin.arregion,
                             win.awcache, win.awlock, win.awprot, win.awqos, win.awregion};

endmodule

// File: tb/tb_axi4_mid_slave_mem.sv
// Self-checking bench for axi4_mid_slave_mem: directed writes, a reset
// mid-burst sequence, then a table of read vectors with expected beats.
module tb_axi4_mid_slave_mem;

    typedef struct packed {
        logic [63:0] araddr;  logic [1:0] arburst; logic [3:0] arcache; logic arid;
        logic [7:0]  arlen;   logic [1:0] arlock;  logic [2:0] arprot;  logic [3:0] arqos;
        logic [3:0]  arregion; logic [2:0] arsize; logic arvalid; logic rready;
    } rd_in_t;

    typedef struct packed {
        logic arready; logic [511:0] rdata; logic rid; logic rlast; logic [1:0] rresp; logic rvalid;
    } rd_out_t;

    typedef struct packed {
        logic [63:0] awaddr;  logic [1:0] awburst; logic [3:0] awcache; logic awid;
        logic [7:0]  awlen;   logic [1:0] awlock;  logic [2:0] awprot;  logic [3:0] awqos;
        logic [3:0]  awregion; logic [2:0] awsize; logic awvalid;
        logic [511:0] wdata;  logic wlast; logic [63:0] wstrb; logic wvalid; logic bready;
    } wr_in_t;

    typedef struct packed {
        logic awready; logic bid; logic [1:0] bresp; logic bvalid; logic wready;
    } wr_out_t;

    typedef struct packed {
        logic [63:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              id;
        logic [3:0][1:0]   resp;
        logic [3:0][511:0] data;
    } rd_vec_t;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [511:0] Z = '0;
    localparam int TMO = 50;

    logic    ap_clk;
    logic    ap_rst_n;
    rd_in_t  rin;
    rd_out_t rout;
    wr_in_t  win;
    wr_out_t wout;
    int      cyc;
    int      n_tests;
    int      n_fail;

    axi4_mid_slave_mem #(.MEM_DEPTH(1024), .ENDIAN_SWAP(1'b0), .ADDR_LSB(6)) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .s_axi_read_in   (rin),
        .s_axi_read_out  (rout),
        .s_axi_write_in  (win),
        .s_axi_write_out (wout)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] pat(input logic [31:0] k);
        return {16{32'h0BEA_0000 + k}};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout required handshake", name);
    endtask

    // Issue one write burst of nbeats W beats (wlast on the last one sent).
    task automatic do_write(input string nm, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic id,
                            input int nbeats, input logic [3:0][511:0] wd,
                            input logic [63:0] strb, input logic [1:0] exp_resp);
        int n;
        win.awaddr = addr; win.awlen = len; win.awburst = burst; win.awsize = size;
        win.awid = id; win.awvalid = 1'b1;
        win.wdata = wd[0]; win.wstrb = strb; win.wlast = (nbeats == 1); win.wvalid = 1'b1;
        check({nm, "_w_holdoff"}, 512'(wout.wready), 512'(0));
        n = 0;
        while (!wout.awready && n < TMO) begin @(negedge ap_clk); n++; end
        if (!wout.awready) begin
            timeout({nm, "_aw"}); win.awvalid = 1'b0; win.wvalid = 1'b0; return;
        end
        @(posedge ap_clk); @(negedge ap_clk);
        win.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            win.wdata = wd[i]; win.wlast = (i == nbeats - 1); win.wvalid = 1'b1;
            n = 0;
            while (!wout.wready && n < TMO) begin @(negedge ap_clk); n++; end
            if (!wout.wready) begin timeout({nm, "_w"}); win.wvalid = 1'b0; return; end
            @(posedge ap_clk); @(negedge ap_clk);
        end
        win.wvalid = 1'b0; win.wlast = 1'b0;
        n = 0;
        while (!wout.bvalid && n < TMO) begin @(negedge ap_clk); n++; end
        if (!wout.bvalid) begin timeout({nm, "_b"}); return; end
        check({nm, "_bresp"}, 512'(wout.bresp), 512'(exp_resp));
        check({nm, "_bid"}, 512'(wout.bid), 512'(id));
        @(posedge ap_clk); @(negedge ap_clk);
    endtask

    // Issue one read burst and compare every beat, including beat timing.
    task automatic do_read(input string nm, input rd_vec_t v);
        int n;
        int t0;
        rin.araddr = v.addr; rin.arlen = v.len; rin.arsize = v.size; rin.arburst = v.burst;
        rin.arid = v.id; rin.arvalid = 1'b1;
        n = 0;
        while (!rout.arready && n < TMO) begin @(negedge ap_clk); n++; end
        if (!rout.arready) begin timeout({nm, "_ar"}); rin.arvalid = 1'b0; return; end
        @(posedge ap_clk); @(negedge ap_clk);
        rin.arvalid = 1'b0;
        t0 = cyc;
        for (int b = 0; b <= int'(v.len); b++) begin
            n = 0;
            while (!rout.rvalid && n < TMO) begin @(negedge ap_clk); n++; end
            if (!rout.rvalid) begin timeout($sformatf("%s_r%0d", nm, b)); return; end
            check($sformatf("%s_b%0d_timing", nm, b), 512'(cyc + 1 - t0), 512'(2 + 2 * b));
            check($sformatf("%s_b%0d_rresp", nm, b), 512'(rout.rresp), 512'(v.resp[b]));
            check($sformatf("%s_b%0d_rdata", nm, b), rout.rdata, v.data[b]);
            check($sformatf("%s_b%0d_rid", nm, b), 512'(rout.rid), 512'(v.id));
            check($sformatf("%s_b%0d_rlast", nm, b), 512'(rout.rlast), 512'(b == int'(v.len)));
            @(posedge ap_clk); @(negedge ap_clk);
        end
        check({nm, "_rvalid_done"}, 512'(rout.rvalid), 512'(0));
    endtask

    function automatic rd_vec_t mk(input logic [63:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst, input logic id,
                                   input logic [3:0][1:0] resp, input logic [3:0][511:0] data);
        rd_vec_t v;
        v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
        v.resp = resp; v.data = data;
        return v;
    endfunction

    rd_vec_t vecs [10];
    logic [511:0] ff_5a;

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;
        rin = '0;
        win = '0;
        rin.rready = 1'b1;
        win.bready = 1'b1;
        ap_rst_n = 1'b1;
        ff_5a = {{63{8'hFF}}, 8'h5A};

        vecs[0] = mk(64'h0,     8'd3, 3'd6, INCR,  1'b0, {OKAY, OKAY, OKAY, OKAY},
                     {pat(3), pat(2), pat(1), pat(0)});
        vecs[1] = mk(64'h200,   8'd0, 3'd6, INCR,  1'b1, {OKAY, OKAY, OKAY, OKAY}, {Z, Z, Z, ff_5a});
        vecs[2] = mk(64'h10000, 8'd1, 3'd6, INCR,  1'b0, {OKAY, OKAY, DECERR, DECERR}, {Z, Z, Z, Z});
        vecs[3] = mk(64'h0,     8'd0, 3'd6, INCR,  1'b1, {OKAY, OKAY, OKAY, OKAY}, {Z, Z, Z, pat(0)});
        vecs[4] = mk(64'h0,     8'd0, 3'd5, INCR,  1'b0, {OKAY, OKAY, OKAY, SLVERR}, {Z, Z, Z, Z});
        vecs[5] = mk(64'h0,     8'd1, 3'd6, WRAP,  1'b1, {OKAY, OKAY, SLVERR, SLVERR}, {Z, Z, Z, Z});
        vecs[6] = mk(64'h500,   8'd0, 3'd6, INCR,  1'b0, {OKAY, OKAY, OKAY, OKAY}, {Z, Z, Z, pat(32'hD)});
        vecs[7] = mk(64'h400,   8'd1, 3'd6, INCR,  1'b1, {OKAY, OKAY, OKAY, OKAY},
                     {Z, Z, pat(32'hC1), pat(32'hC0)});
        vecs[8] = mk(64'h40,    8'd1, 3'd6, FIXED, 1'b0, {OKAY, OKAY, OKAY, OKAY}, {Z, Z, pat(1), pat(1)});
        vecs[9] = mk(64'hFFC0,  8'd1, 3'd6, INCR,  1'b1, {OKAY, OKAY, DECERR, OKAY},
                     {Z, Z, Z, pat(32'hE)});

        // Reset: outputs forced to 0, ready rises one cycle after release.
        #2 ap_rst_n = 1'b0;
        #1;
        check("rst_read_out", 512'(rout), 512'(0));
        check("rst_write_out", 512'(wout), 512'(0));
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        check("rst_arready_before_edge", 512'(rout.arready), 512'(0));
        @(negedge ap_clk);
        check("rst_arready_after_edge", 512'(rout.arready), 512'(1));
        check("rst_awready_after_edge", 512'(wout.awready), 512'(1));

        // Single write then read back.
        do_write("w_single", 64'h40, 8'd0, INCR, 3'd6, 1'b1, 1, {Z, Z, Z, pat(32'hA)}, '1, OKAY);
        do_read("r_single", mk(64'h40, 8'd0, 3'd6, INCR, 1'b1, {OKAY, OKAY, OKAY, OKAY},
                               {Z, Z, Z, pat(32'hA)}));

        // Directed write traffic consumed by the read table below.
        do_write("w_incr", 64'h0, 8'd3, INCR, 3'd6, 1'b0, 4, {pat(3), pat(2), pat(1), pat(0)}, '1, OKAY);
        do_write("w_preload", 64'h200, 8'd0, INCR, 3'd6, 1'b0, 1, {Z, Z, Z, {512{1'b1}}}, '1, OKAY);
        do_write("w_strb", 64'h200, 8'd0, INCR, 3'd6, 1'b1, 1, {Z, Z, Z, 512'h5A}, 64'h1, OKAY);
        do_write("w_d", 64'h500, 8'd0, INCR, 3'd6, 1'b0, 1, {Z, Z, Z, pat(32'hD)}, '1, OKAY);
        do_write("w_size", 64'h500, 8'd0, INCR, 3'd5, 1'b1, 1, {Z, Z, Z, pat(32'h55)}, '1, SLVERR);
        do_write("w_top", 64'hFFC0, 8'd0, INCR, 3'd6, 1'b0, 1, {Z, Z, Z, pat(32'hE)}, '1, OKAY);
        do_write("w_oor", 64'h10000, 8'd0, INCR, 3'd6, 1'b1, 1, {Z, Z, Z, pat(32'hBAD)}, '1, DECERR);
        do_write("w_early_last", 64'h400, 8'd3, INCR, 3'd6, 1'b0, 2,
                 {Z, Z, pat(32'hC1), pat(32'hC0)}, '1, SLVERR);

        // Reset during beat 2 of a len-7 read.
        rin.araddr = 64'h0; rin.arlen = 8'd7; rin.arsize = 3'd6; rin.arburst = INCR;
        rin.arid = 1'b1; rin.arvalid = 1'b1;
        n = 0;
        while (!rout.arready && n < TMO) begin @(negedge ap_clk); n++; end
        if (!rout.arready) timeout("rst_mid_ar");
        @(posedge ap_clk); @(negedge ap_clk);
        rin.arvalid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            n = 0;
            while (!rout.rvalid && n < TMO) begin @(negedge ap_clk); n++; end
            if (b < 2) begin @(posedge ap_clk); @(negedge ap_clk); end
        end
        check("rst_mid_rvalid_beat2", 512'(rout.rvalid), 512'(1));
        ap_rst_n = 1'b0;
        #1;
        check("rst_mid_read_out", 512'(rout), 512'(0));
        check("rst_mid_write_out", 512'(wout), 512'(0));
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("rst_mid_arready", 512'(rout.arready), 512'(1));
        check("rst_mid_no_rvalid", 512'(rout.rvalid), 512'(0));
        @(negedge ap_clk);
        check("rst_mid_no_rvalid_later", 512'(rout.rvalid), 512'(0));

        // Read vector table.
        for (int i = 0; i < 10; i++) do_read($sformatf("rd%0d", i), vecs[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
